// File: rtl/mean_pkg.sv
// Constants shared by the window-mean feeder and the downstream divider wrapper.
package mean_pkg;

  localparam int DATA_W  = 32;
  localparam int CNT_W   = 8;
  localparam int MAX_CNT = 255;

  localparam logic [DATA_W-1:0] SUM_MAX = {DATA_W{1'b1}};

  typedef enum logic {
    EMPTY = 1'b0,
    ACCUM = 1'b1
  } win_state_t;

endpackage

// File: rtl/sat_add_32.sv
// Combinational saturating adder: accumulator plus sample, clamped to the
// all-ones value of DATA_W bits, with a flag when clamping happened.
module sat_add_32 #(
  parameter int DATA_W = mean_pkg::DATA_W
) (
  input  logic [DATA_W:0]   acc,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] sum,
  output logic              ovf
);

  logic [DATA_W+1:0] full;

  always_comb begin
    full = {1'b0, acc} + {2'b00, sample};
    ovf  = |full[DATA_W+1:DATA_W];
    sum  = ovf ? {DATA_W{1'b1}} : full[DATA_W-1:0];
  end

endmodule

// File: rtl/window_mean_accum_32_8.sv
// Accumulates a window of samples and emits (sum, count) as one dividend /
// divisor transaction; windows close on tlast, flush or MAX_CNT samples.
module window_mean_accum_32_8 #(
  parameter int DATA_W  = mean_pkg::DATA_W,
  parameter int CNT_W   = mean_pkg::CNT_W,
  parameter int MAX_CNT = mean_pkg::MAX_CNT
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              s_axis_tvalid,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              flush,
  output logic              m_axis_a_tvalid,
  output logic [DATA_W-1:0] m_axis_a_tdata,
  output logic              m_axis_b_tvalid,
  output logic [CNT_W-1:0]  m_axis_b_tdata,
  output logic              overflow
);

  import mean_pkg::*;

  win_state_t        state;
  logic [DATA_W:0]   acc;
  logic [CNT_W-1:0]  cnt;
  logic              sat;

  logic [DATA_W-1:0] add_sum;
  logic              add_ovf;

  logic              beat;
  logic [CNT_W-1:0]  next_cnt;
  logic              close;
  logic [DATA_W-1:0] close_sum;
  logic [CNT_W-1:0]  close_cnt;
  logic              close_ovf;

  sat_add_32 #(.DATA_W(DATA_W)) u_sat_add (
    .acc    (acc),
    .sample (s_axis_tdata),
    .sum    (add_sum),
    .ovf    (add_ovf)
  );

  // NOTE: every always_comb output gets a value on every path (here, all
  // unconditionally) so no latch can be inferred.
  always_comb begin
    beat      = s_axis_tvalid;
    next_cnt  = cnt + CNT_W'(1);
    close     = (beat && (s_axis_tlast || next_cnt == CNT_W'(MAX_CNT))) ||
                (flush && (state == ACCUM || beat));
    close_sum = beat ? add_sum  : acc[DATA_W-1:0];
    close_cnt = beat ? next_cnt : cnt;
    close_ovf = sat | (beat & add_ovf);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state           <= EMPTY;
      acc             <= '0;
      cnt             <= '0;
      sat             <= 1'b0;
      m_axis_a_tvalid <= 1'b0;
      m_axis_a_tdata  <= '0;
      m_axis_b_tdata  <= '0;
      overflow        <= 1'b0;
    end else begin
      m_axis_a_tvalid <= close;
      if (close) begin
        // Beat and flush together fold the beat into the closing window.
        m_axis_a_tdata <= close_sum;
        m_axis_b_tdata <= close_cnt;
        overflow       <= close_ovf;
        acc            <= '0;
        cnt            <= '0;
        sat            <= 1'b0;
        state          <= EMPTY;
      end else if (beat) begin
        acc   <= {1'b0, add_sum};
        cnt   <= next_cnt;
        sat   <= close_ovf;
        state <= ACCUM;
      end
    end
  end

  // Divisor and dividend always travel as one transaction.
  assign m_axis_b_tvalid = m_axis_a_tvalid;

endmodule
